// File: rtl/peek_fifo_pkg.sv
// Default sizing for the per-VC peek FIFO; a router-wide flit width can be sourced here.
package peek_fifo_pkg;
  localparam int unsigned PF_DATA_WIDTH   = 32;
  localparam int unsigned PF_DEPTH_BITS   = 3;
  localparam int unsigned PF_IN_BUFFERS   = 2;
endpackage

// File: rtl/peek_fifo.sv
// Single-clock FIFO with combinational head peek/pop and early-full credit margin.
// Instantiated positionally per VC, so the port order below must not change.
module peek_fifo
  import peek_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = PF_DATA_WIDTH,
  parameter int unsigned Q_DEPTH_BITS = PF_DEPTH_BITS,
  parameter int unsigned Q_IN_BUFFERS = PF_IN_BUFFERS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  wrtEn,
  input  logic                  rdEn,
  input  logic                  peek,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  valid,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH       = 1 << Q_DEPTH_BITS;
  localparam int unsigned FULL_THRESH = DEPTH - Q_IN_BUFFERS;
  localparam logic [Q_DEPTH_BITS:0] LP_DEPTH  = (Q_DEPTH_BITS+1)'(DEPTH);
  localparam logic [Q_DEPTH_BITS:0] LP_THRESH = (Q_DEPTH_BITS+1)'(FULL_THRESH);

  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic [Q_DEPTH_BITS-1:0] r_head;
  logic [Q_DEPTH_BITS-1:0] r_tail;
  logic [Q_DEPTH_BITS:0]   r_count;

  logic w_empty;
  logic w_wr;
  logic w_pop;

  assign w_empty = (r_count == '0);
  // Writes are refused only at physical capacity, even if a pop lands in the same cycle.
  assign w_wr    = wrtEn && (r_count < LP_DEPTH);
  assign w_pop   = rdEn && !w_empty;

  assign empty     = w_empty;
  assign full      = (r_count >= LP_THRESH);
  assign valid     = (rdEn | peek) & ~w_empty;
  assign read_data = valid ? r_mem[r_head] : '0;

  // Storage has no reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (w_wr && !reset) begin
      r_mem[r_tail] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_peek_fifo.sv
// Scoreboard bench for peek_fifo at default sizing (DEPTH=8, two slack entries).
module tb_peek_fifo;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] write_data = '0;
  logic        wrtEn = 1'b0;
  logic        rdEn = 1'b0;
  logic        peek = 1'b0;
  logic [31:0] read_data;
  logic        valid;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_fail   = 0;

  logic        mon_en = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_q [$];

  peek_fifo dut (
    .clk        (clk),
    .reset      (reset),
    .write_data (write_data),
    .wrtEn      (wrtEn),
    .rdEn       (rdEn),
    .peek       (peek),
    .read_data  (read_data),
    .valid      (valid),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Monitor: samples on the falling edge, away from state updates.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [31:0] d;
      n_checks++;
      if (valid !== exp_valid) begin
        n_fail++;
        $display("FAIL valid: got %b expected %b at %0t", valid, exp_valid, $time);
      end
      if (exp_valid) begin
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL scoreboard_underrun: valid expected but no data queued at %0t", $time);
        end else begin
          d = exp_q.pop_front();
          n_checks++;
          if (read_data !== d) begin
            n_fail++;
            $display("FAIL read_data: got %h expected %h at %0t", read_data, d, $time);
          end
        end
      end else begin
        n_checks++;
        if (read_data !== 32'h0) begin
          n_fail++;
          $display("FAIL read_data_idle: got %h expected 0 at %0t", read_data, $time);
        end
      end
    end
  end

  task automatic cyc(input logic wr, input logic [31:0] d, input logic rd, input logic pk,
                     input logic ev, input logic [31:0] ed);
    wrtEn = wr;
    write_data = d;
    rdEn = rd;
    peek = pk;
    exp_valid = ev;
    if (ev) exp_q.push_back(ed);
    @(posedge clk);
    #1;
    wrtEn = 1'b0;
    rdEn = 1'b0;
    peek = 1'b0;
    exp_valid = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic e_empty, input logic e_full);
    n_checks++;
    if (empty !== e_empty || full !== e_full) begin
      n_fail++;
      $display("FAIL %s: empty=%b full=%b expected empty=%b full=%b", name, empty, full,
               e_empty, e_full);
    end
  endtask

  task automatic wr(input logic [31:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic rd(input logic [31:0] ed);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, ed);
  endtask

  initial begin
    reset = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state, idle peek on empty.
    chk_flags("after_reset", 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

    // Peek is non-destructive, then ordered pops.
    wr(32'hA1); wr(32'hA2); wr(32'hA3);
    chk_flags("three_words", 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA1);
    rd(32'hA1); rd(32'hA2); rd(32'hA3);
    chk_flags("drained_a", 1'b1, 1'b0);

    // Early full at 6, physical full at 8, overflow write dropped.
    for (int i = 1; i <= 5; i++) wr(32'(i));
    chk_flags("count5", 1'b0, 1'b0);
    wr(32'h06);
    chk_flags("count6_full", 1'b0, 1'b1);
    wr(32'h07); wr(32'h08);
    chk_flags("count8", 1'b0, 1'b1);
    wr(32'hFF);
    chk_flags("overflow", 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) rd(32'(i));
    chk_flags("drained_full", 1'b1, 1'b0);

    // Streaming with count held at 3 across several pointer wraps.
    wr(32'h10); wr(32'h11); wr(32'h12);
    for (int i = 0; i < 20; i++) cyc(1'b1, 32'h13 + 32'(i), 1'b1, 1'b0, 1'b1, 32'h10 + 32'(i));
    chk_flags("stream_count3", 1'b0, 1'b0);
    rd(32'h24); rd(32'h25); rd(32'h26);
    chk_flags("stream_drained", 1'b1, 1'b0);

    // Pop and write together on a one-entry FIFO.
    wr(32'h55);
    cyc(1'b1, 32'h66, 1'b1, 1'b0, 1'b1, 32'h55);
    chk_flags("swap_one", 1'b0, 1'b0);
    rd(32'h66);
    chk_flags("swap_drained", 1'b1, 1'b0);

    // Read on empty: no valid, no state change.
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_flags("read_empty", 1'b1, 1'b0);

    // rdEn with peek pops; write into empty is not bypassed.
    wr(32'h77);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h77);
    chk_flags("rd_peek_pops", 1'b1, 1'b0);
    cyc(1'b1, 32'h88, 1'b1, 1'b0, 1'b0, 32'h0);
    chk_flags("no_bypass", 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h88);
    rd(32'h88);

    // Reset mid-operation with rdEn held.
    for (int i = 0; i < 5; i++) wr(32'h31 + 32'(i));
    reset = 1'b1;
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h31);
    reset = 1'b0;
    chk_flags("mid_reset", 1'b1, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    wr(32'h41); wr(32'h42);
    rd(32'h41); rd(32'h42);
    chk_flags("post_reset", 1'b1, 1'b0);

    @(posedge clk);
    #1;
    mon_en = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d entries unconsumed, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
